req_issuer: RTL and testbench

Upstream request stage for the synthesis benchmarks: it turns environment `start` events into single-cycle requests toward the downstream checker, which receives them on its `i` input. It tracks outstanding requests with a credit counter and retires them on `response` pulses from the downstream stage. It exposes the request on `_rt_get` for the real-time model checker. It raises a sticky `error` on credit overflow, a spurious response, or a missed deadline.

---
 rtl/req_issuer.sv | 150 +++++++++++++++
 tb/tb_req_issuer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/req_issuer.sv
// Request issuer: turns start events into registered request pulses and tracks outstanding credits.
// Optional deadline timer in WAIT is built only when REQ_ISSUER_DEADLINE_EN is defined.
module req_issuer #(
    parameter int MAX_OUT  = 3,
    parameter int DEADLINE = 8,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             controllable_ack,
    input  logic             response,
    output logic             req,
    output logic             _rt_get,
    output logic [CNT_W-1:0] outstanding,
    output logic             busy,
    output logic             error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

    if (MAX_OUT < 1 || MAX_OUT > (2 ** CNT_W) - 1 || DEADLINE < 1) begin : g_bad_cfg
        $error("req_issuer: illegal MAX_OUT/DEADLINE/CNT_W combination");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             underflow_s;
    logic [CNT_W-1:0] out_ret_s;

`ifdef REQ_ISSUER_DEADLINE_EN
    // Timer is widened when needed so it can actually hold the DEADLINE value.
    localparam int TMR_W = ($clog2(DEADLINE + 1) > CNT_W) ? $clog2(DEADLINE + 1) : CNT_W;
    localparam logic [TMR_W-1:0] DL_C = TMR_W'(DEADLINE);
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    // Next-state, credit and timer computation
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        underflow_s = response && (out_q == {CNT_W{1'b0}});
        out_ret_s   = response ? (out_q - CNT_W'(1)) : out_q;
`ifdef REQ_ISSUER_DEADLINE_EN
        timer_d     = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (underflow_s) begin
                    state_d = ERR;
                end else begin
                    out_d   = out_ret_s;
                    state_d = start ? ISSUE : IDLE;
                end
            end
            ISSUE: begin
                if (underflow_s) begin
                    state_d = ERR;
                end else if (controllable_ack && (out_ret_s == MAX_C)) begin
                    state_d = ERR;
                end else if (controllable_ack) begin
                    out_d   = out_ret_s + CNT_W'(1);
                    state_d = WAIT;
`ifdef REQ_ISSUER_DEADLINE_EN
                    timer_d = {TMR_W{1'b0}};
`endif
                end else begin
                    out_d   = out_ret_s;
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (underflow_s) begin
                    state_d = ERR;
`ifdef REQ_ISSUER_DEADLINE_EN
                end else if (!response && (timer_q == DL_C) && (out_q != {CNT_W{1'b0}})) begin
                    state_d = ERR;
`endif
                end else begin
                    out_d = out_ret_s;
`ifdef REQ_ISSUER_DEADLINE_EN
                    if (response) begin
                        timer_d = {TMR_W{1'b0}};
                    end else if (timer_q != DL_C) begin
                        timer_d = timer_q + TMR_W'(1);
                    end else begin
                        timer_d = timer_q;
                    end
`endif
                    if (out_ret_s == {CNT_W{1'b0}}) begin
                        state_d = IDLE;
                    end else if (start) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = ERR;
            end
        endcase
        req_d  = (state_d == ISSUE);
        busy_d = (state_d == ISSUE) || (state_d == WAIT);
        err_d  = (state_d == ERR);
    end

    // State, credit counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= {CNT_W{1'b0}};
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef REQ_ISSUER_DEADLINE_EN
            timer_q <= {TMR_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef REQ_ISSUER_DEADLINE_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign req         = req_q;
    assign _rt_get     = req_q;
    assign outstanding = out_q;
    assign busy        = busy_q;
    assign error       = err_q;

endmodule

// File: tb/tb_req_issuer.sv
// Scoreboard bench for req_issuer: the driver queues hand-computed expectations, a monitor pops and compares.
module tb_req_issuer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       controllable_ack = 1'b0;
    logic       response = 1'b0;
    logic       req, rt_get, busy, error;
    logic [2:0] outstanding;

    typedef struct packed {
        logic       req;
        logic       rt;
        logic       busy;
        logic       err;
        logic [2:0] out;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    req_issuer #(.MAX_OUT(3), .DEADLINE(8), .CNT_W(3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .controllable_ack (controllable_ack),
        .response         (response),
        .req              (req),
        ._rt_get          (rt_get),
        .outstanding      (outstanding),
        .busy             (busy),
        .error            (error)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic r, input logic b, input logic e, input logic [2:0] o);
        obs_t v;
        v = '{req: r, rt: r, busy: b, err: e, out: o};
        return v;
    endfunction

    function automatic obs_t observe();
        obs_t v;
        v = '{req: req, rt: rt_get, busy: busy, err: error, out: outstanding};
        return v;
    endfunction

    task automatic compare(input string nm, input obs_t e);
        obs_t a;
        a = observe();
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got req=%b rt=%b busy=%b err=%b out=%0d, want req=%b rt=%b busy=%b err=%b out=%0d",
                     nm, a.req, a.rt, a.busy, a.err, a.out, e.req, e.rt, e.busy, e.err, e.out);
        end
    endtask

    // Monitor: one expectation is consumed per clock, sampled after the edge settles.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            compare(name_q.pop_front(), exp_q.pop_front());
        end
    end

    task automatic step(input string nm, input logic s, input logic a, input logic r,
                        input logic er, input logic eb, input logic ee, input logic [2:0] eo);
        @(negedge clk);
        start            = s;
        controllable_ack = a;
        response         = r;
        exp_q.push_back(mk(er, eb, ee, eo));
        name_q.push_back(nm);
    endtask

    task automatic async_reset(input string nm);
        @(negedge clk);
        start = 1'b0; controllable_ack = 1'b0; response = 1'b0;
        #2 rst_n = 1'b0;
        #1 compare(nm, mk(1'b0, 1'b0, 1'b0, 3'd0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        compare("reset_state", mk(1'b0, 1'b0, 1'b0, 3'd0));
        rst_n = 1'b1;

        // Basic request / ack / response round trip
        step("t1_start",  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        step("t1_ack",    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
        step("t1_resp",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        step("t1_idle",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        // Ack+response at full credit is not an overflow, then overflow for real
        for (int i = 0; i < 3; i++) begin
            step("t2_start", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'(i));
            step("t2_ack",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'(i + 1));
        end
        step("t2_start4",   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3);
        step("t2_ackresp",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
        step("t2_start5",   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3);
        step("t2_overflow", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
        step("t2_sticky",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
        async_reset("t6_async_reset_err");

        // Spurious response while idle
        step("t3_spurious", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        step("t3_no_req",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        step("t3_sticky",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        async_reset("t3_reset");

        // Response during ISSUE, and ack+response in the same ISSUE cycle
        step("t5_start",    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        step("t5_ack",      1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
        step("t5_start2",   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        step("t5_iss_resp", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        step("t5_ack2",     1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
        step("t5_start3",   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        step("t5_ackresp",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
        step("t5_drain",    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // Deadline behaviour
        step("t4_start", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        step("t4_ack",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
`ifdef REQ_ISSUER_DEADLINE_EN
        for (int i = 0; i < 8; i++) begin
            step("t4_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
        end
        step("t4_timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
        step("t4_sticky",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        async_reset("t4_reset");
`else
        for (int i = 0; i < 20; i++) begin
            step("t4_no_timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
        end
        step("t4_drain", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
`endif
        step("end_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
